dog_extrema_stream: RTL
=======================

// Module: dog_extrema_stream
// PURPOSE
//  Streaming 3x3x3 scale-space extremum detector for three DoG layers (below/centre/above).
//  Replaces full-frame storage with two line buffers per layer; one verdict per interior pixel.
//  Sits between the DoG subtractor stage and the keypoint descriptor/packer.
//  Adds signed data, selectable max/min/both mode, contrast threshold and pixel coordinates.
// PARAMETERS
//  DATA_W  16   DoG sample width, two's complement signed
//  IMG_W   320  pixels per line (>=3)
//  IMG_H   480  lines per frame (>=3)
//  X_W     $clog2(IMG_W)  x coordinate width (derived, localparam)
//  Y_W     $clog2(IMG_H)  y coordinate width (derived, localparam)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  in_valid    in   1       diff1..3 valid this cycle; raster order, gaps allowed
//  diff1       in   DATA_W  DoG layer below (signed)
//  diff2       in   DATA_W  DoG centre layer (signed)
//  diff3       in   DATA_W  DoG layer above (signed)
//  cfg_mode    in   2       bit0 detect maxima, bit1 detect minima
//  cfg_thresh  in   DATA_W  unsigned contrast threshold on |centre|
//  out_valid   out  1       verdict for (out_x,out_y) this cycle
//  out_flag    out  2       bit0 maximum, bit1 minimum (never both)
//  out_x       out  X_W     centre column, 1..IMG_W-2
//  out_y       out  Y_W     centre row, 1..IMG_H-2
//  frame_done  out  1       one-cycle pulse coincident with last verdict of frame
// BEHAVIOUR
//  - Reset: all outputs 0; x/y counters 0; window-valid cleared; line buffer contents don't-care.
//  - Accept pixel every cycle in_valid=1; no backpressure. x wraps IMG_W-1->0, y increments;
//    y wraps IMG_H-1->0 (next frame follows back-to-back, no idle cycle required).
//  - Per layer: two line delays + 3x3 shift window; window complete when accepted (x,y) has x>=2,y>=2.
//  - Verdict for centre (x-1,y-1) registered: out_valid rises the cycle after accepting (x,y).
//    Exactly (IMG_W-2)*(IMG_H-2) verdicts per frame; border pixels produce none.
//  - Max: c=diff2 centre strictly > all 26 neighbours (signed). Min: strictly < all 26. Any tie -> no flag.
//  - Flag gated by cfg_mode bit; mode 00 still pulses out_valid with out_flag=0.
//  - cfg_mode, cfg_thresh sampled when pixel (0,0) accepted; held constant for that frame.
//  - |c| computed in DATA_W+1 bits (|-2^(DATA_W-1)| must not overflow).
//  - frame_done with verdict for (IMG_W-2,IMG_H-2); out_x/out_y/out_flag hold last value when out_valid=0.
//  - Reset mid-frame: counters restart; first verdict only after fresh rows 0..2 received.
//  - in_valid gaps mid-line: window frozen, no verdict, no state advance.
// CONFIGURATION
//  KP_CONTRAST_THRESH_EN defined: flag additionally requires |c| > cfg_thresh (strict).
//  Undefined: cfg_thresh ignored (no compare logic); flag depends on extremum test only.
// STRUCTURE
//  Package dog_kp_pkg: MODE_MAX/MODE_MIN bit indices, FLAG_MAX/FLAG_MIN indices,
//   signed sample typedef, comparison helper function gt26/lt26.
//  Sub-module dog_line_buffer (DATA_W, IMG_W): two-line delay with taps, instantiated x3.
// TESTING (IMG_W=8, IMG_H=6, DATA_W=16)
//  1 All layers 0, mode 11 -> 24 out_valid pulses, out_flag=0, frame_done on (6,4) only.
//  2 diff2(3,2)=100, others 0, mode 01 -> flag 01 at out_x=3,out_y=2, 0 elsewhere; latency 1 after (4,3).
//  3 diff2(4,3)=-32768, others 0, mode 10 -> flag 10 at (4,3); mode 01 -> no flag.
//  4 diff2(3,2)=100, diff3(3,2)=100 (tie) -> flag 0 at (3,2).
//  5 THRESH_EN, cfg_thresh=100: centre 100 -> no flag; centre 101 -> flag 01.
//  6 Two back-to-back frames with in_valid gaps; rst_n low mid-frame 1 -> no verdicts until
//    row 2 col 2 of fresh data; frame 2 yields exactly 24 verdicts.

Source files
------------

// File: rtl/dog_kp_pkg.sv
// Shared definitions for the DoG scale-space extremum detector.
// Holds mode/flag bit indices, the widened signed sample type used for
// comparisons, and the 26-neighbour strict comparison helpers.
package dog_kp_pkg;

    localparam int MODE_MAX = 0;
    localparam int MODE_MIN = 1;
    localparam int FLAG_MAX = 0;
    localparam int FLAG_MIN = 1;

    // Comparisons run on samples sign-extended to this width; DATA_W <= CMP_W.
    localparam int CMP_W = 32;
    localparam int NBR_N = 26;

    typedef logic signed [CMP_W-1:0] sample_t;
    typedef sample_t nbr_t [NBR_N];

    // True when c is strictly greater than every neighbour; any tie fails.
    function automatic logic gt26(input sample_t c, input nbr_t n);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NBR_N; i++) begin
            if (!(c > n[i])) r = 1'b0;
        end
        return r;
    endfunction

    // True when c is strictly less than every neighbour; any tie fails.
    function automatic logic lt26(input sample_t c, input nbr_t n);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NBR_N; i++) begin
            if (!(c < n[i])) r = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/dog_line_buffer.sv
// Two-line delay plus 3x3 shift window for one DoG layer.
// win_o packs 9 samples, index (row*3 + col): row 0 = line y-2, row 2 = line y;
// col 0 = column x-2, col 2 = the column being accepted this cycle.
// Column 2 is combinational so the verdict can be registered on the accept edge.
module dog_line_buffer
    import dog_kp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 320,
    localparam int X_W   = $clog2(IMG_W)
) (
    input  logic                clk,
    input  logic                en_i,
    input  logic [X_W-1:0]      x_i,
    input  logic [DATA_W-1:0]   din_i,
    output logic [9*DATA_W-1:0] win_o
);

    logic [DATA_W-1:0] line1_q [IMG_W];
    logic [DATA_W-1:0] line2_q [IMG_W];
    logic [DATA_W-1:0] col0_q  [3];
    logic [DATA_W-1:0] col1_q  [3];
    logic [DATA_W-1:0] col_d   [3];

    // Incoming column: two delayed lines at this x plus the live sample.
    always_comb begin
        col_d[0] = line2_q[x_i];
        col_d[1] = line1_q[x_i];
        col_d[2] = din_i;
    end

    // Line delays: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (en_i) begin
            line1_q[x_i] <= din_i;
            line2_q[x_i] <= line1_q[x_i];
        end
    end

    // Shift the two stored window columns only on accepted pixels.
    always_ff @(posedge clk) begin
        if (en_i) begin
            col0_q <= col1_q;
            col1_q <= col_d;
        end
    end

    // Pack the 3x3 window.
    always_comb begin
        win_o = '0;
        for (int r = 0; r < 3; r++) begin
            win_o[(r*3 + 0)*DATA_W +: DATA_W] = col0_q[r];
            win_o[(r*3 + 1)*DATA_W +: DATA_W] = col1_q[r];
            win_o[(r*3 + 2)*DATA_W +: DATA_W] = col_d[r];
        end
    end

endmodule

// File: rtl/dog_extrema_stream.sv
// Streaming 3x3x3 scale-space extremum detector over three DoG layers.
// Optional build macro KP_CONTRAST_THRESH_EN: a flag additionally needs
// |centre| > cfg_thresh (strict); without it cfg_thresh is ignored.
// Handshake: a pixel is taken on every rising edge with in_valid=1 (no
// backpressure); out_valid is a one-cycle strobe, one cycle after the accept
// of the pixel that completes the window centred at (out_x, out_y).
module dog_extrema_stream
    import dog_kp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 480,
    localparam int X_W   = $clog2(IMG_W),
    localparam int Y_W   = $clog2(IMG_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] diff1,
    input  logic [DATA_W-1:0] diff2,
    input  logic [DATA_W-1:0] diff3,
    input  logic [1:0]        cfg_mode,
    input  logic [DATA_W-1:0] cfg_thresh,
    output logic              out_valid,
    output logic [1:0]        out_flag,
    output logic [X_W-1:0]    out_x,
    output logic [Y_W-1:0]    out_y,
    output logic              frame_done
);

    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [1:0]           mode_q, mode_d;
    logic                 last_x, last_y, at_origin, win_ok;
    logic [9*DATA_W-1:0]  win1, win2, win3;
    sample_t              c;
    nbr_t                 nbr;
    logic                 thr_ok;
    logic [1:0]           flag_d;

    logic                 out_valid_q, frame_done_q;
    logic [1:0]           out_flag_q;
    logic [X_W-1:0]       out_x_q;
    logic [Y_W-1:0]       out_y_q;

    assign last_x    = (x_q == X_W'(IMG_W - 1));
    assign last_y    = (y_q == Y_W'(IMG_H - 1));
    assign at_origin = in_valid && (x_q == '0) && (y_q == '0);
    assign win_ok    = in_valid && (x_q >= X_W'(2)) && (y_q >= Y_W'(2));

    // Raster position of the next pixel to be accepted; frames run back-to-back.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (in_valid) begin
            if (last_x) begin
                x_d = '0;
                y_d = last_y ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Mode is latched with pixel (0,0) and held for the whole frame.
    always_comb begin
        mode_d = at_origin ? cfg_mode : mode_q;
    end

    // Position counters and frame configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            mode_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            mode_q <= mode_d;
        end
    end

    dog_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lb_below (
        .clk(clk), .en_i(in_valid), .x_i(x_q), .din_i(diff1), .win_o(win1)
    );
    dog_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lb_centre (
        .clk(clk), .en_i(in_valid), .x_i(x_q), .din_i(diff2), .win_o(win2)
    );
    dog_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lb_above (
        .clk(clk), .en_i(in_valid), .x_i(x_q), .din_i(diff3), .win_o(win3)
    );

    // Gather the 26 neighbours: all 9 of the outer layers, 8 of the centre layer.
    always_comb begin
        nbr = '{default: '0};
        for (int k = 0; k < 9; k++) begin
            nbr[k]     = sample_t'($signed(win1[k*DATA_W +: DATA_W]));
            nbr[9 + k] = sample_t'($signed(win3[k*DATA_W +: DATA_W]));
        end
        for (int k = 0; k < 4; k++) begin
            nbr[18 + k] = sample_t'($signed(win2[k*DATA_W +: DATA_W]));
            nbr[22 + k] = sample_t'($signed(win2[(k + 5)*DATA_W +: DATA_W]));
        end
        c = sample_t'($signed(win2[4*DATA_W +: DATA_W]));
    end

`ifdef KP_CONTRAST_THRESH_EN
    logic [DATA_W-1:0] thresh_q, thresh_d;
    logic [DATA_W:0]   centre_ext, abs_c;

    // Threshold is latched alongside the mode at pixel (0,0).
    always_comb begin
        thresh_d = at_origin ? cfg_thresh : thresh_q;
    end

    // Threshold register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) thresh_q <= '0;
        else        thresh_q <= thresh_d;
    end

    // |centre| needs one extra bit so the most negative sample stays positive.
    always_comb begin
        centre_ext = {win2[5*DATA_W-1], win2[4*DATA_W +: DATA_W]};
        abs_c      = centre_ext[DATA_W] ? (~centre_ext + 1'b1) : centre_ext;
        thr_ok     = (abs_c > {1'b0, thresh_q});
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^cfg_thresh;
    assign thr_ok        = 1'b1;
`endif

    // Verdict: strict extremum, gated by the frame's mode and contrast test.
    always_comb begin
        flag_d           = '0;
        flag_d[FLAG_MAX] = mode_q[MODE_MAX] && thr_ok && gt26(c, nbr);
        flag_d[FLAG_MIN] = mode_q[MODE_MIN] && thr_ok && lt26(c, nbr);
    end

    // Registered outputs; position and flag hold between verdicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_flag_q   <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
        end else begin
            out_valid_q  <= win_ok;
            frame_done_q <= win_ok && last_x && last_y;
            if (win_ok) begin
                out_flag_q <= flag_d;
                out_x_q    <= x_q - 1'b1;
                out_y_q    <= y_q - 1'b1;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign out_flag   = out_flag_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;

endmodule
